// File: rtl/ast_byte_packer_if.sv
// Avalon-ST bundle for ast_byte_packer: byte-wide sink side plus wide source side.
// slave = packer view, master = environment view.
interface ast_byte_packer_if #(
    parameter int unsigned AST_SOURCE_SYMBOLS = 8,
    parameter int unsigned AST_SOURCE_EMPTY_W = $clog2(AST_SOURCE_SYMBOLS),
    parameter int unsigned BYTE_W             = 8
) ();
    logic [BYTE_W-1:0]                         ast_sink_data_i;
    logic                                      ast_sink_ready_o;
    logic                                      ast_sink_valid_i;
    logic                                      ast_sink_startofpacket_i;
    logic                                      ast_sink_endofpacket_i;
    logic [AST_SOURCE_SYMBOLS-1:0][BYTE_W-1:0] ast_source_data_o;
    logic                                      ast_source_ready_i;
    logic                                      ast_source_valid_o;
    logic                                      ast_source_startofpacket_o;
    logic                                      ast_source_endofpacket_o;
    logic [AST_SOURCE_EMPTY_W-1:0]             ast_source_empty_o;

    modport slave (
        input  ast_sink_data_i, ast_sink_valid_i, ast_sink_startofpacket_i,
               ast_sink_endofpacket_i, ast_source_ready_i,
        output ast_sink_ready_o, ast_source_data_o, ast_source_valid_o,
               ast_source_startofpacket_o, ast_source_endofpacket_o, ast_source_empty_o
    );

    modport master (
        output ast_sink_data_i, ast_sink_valid_i, ast_sink_startofpacket_i,
               ast_sink_endofpacket_i, ast_source_ready_i,
        input  ast_sink_ready_o, ast_source_data_o, ast_source_valid_o,
               ast_source_startofpacket_o, ast_source_endofpacket_o, ast_source_empty_o
    );
endinterface

// File: rtl/ast_byte_packer.sv
// Byte-to-beat Avalon-ST packer: collects a 1-symbol packet stream into
// AST_SOURCE_SYMBOLS-wide beats with sop/eop/empty, flushing malformed packets.
// Optional: define AST_PACKER_ERR_CNT_EN to add the saturating err_cnt_o counter.
module ast_byte_packer #(
    parameter int unsigned AST_SOURCE_SYMBOLS = 8,
    parameter int unsigned AST_SOURCE_ORDER   = 1,
    parameter int unsigned AST_SOURCE_EMPTY_W = $clog2(AST_SOURCE_SYMBOLS),
    parameter int unsigned BYTE_W             = 8
) (
    input  logic             main_clk_i,
    input  logic             main_srst_i,
    ast_byte_packer_if.slave ast
`ifdef AST_PACKER_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt_o
`endif
);
    localparam int unsigned S  = AST_SOURCE_SYMBOLS;
    localparam int unsigned CW = AST_SOURCE_EMPTY_W;

    typedef logic [S-1:0][BYTE_W-1:0] beat_t;
    typedef logic [S-2:0][BYTE_W-1:0] acc_t;
    // StPend: a sop+eop byte arrived in the same cycle as a flush; it waits in slot 0.
    typedef enum logic [1:0] {StIdle, StPkt, StPend} state_e;

    state_e        state_q, state_d;
    acc_t          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    beat_t         out_data_q, out_data_d;
    logic          out_sop_q, out_sop_d;
    logic          out_eop_q, out_eop_d;
    logic [CW-1:0] out_empty_q, out_empty_d;
    logic          out_valid_q, out_valid_d;

    logic          out_free, sink_ready, accept, err_inc, start_new;
    logic          ld_en, ld_sop, ld_eop;
    beat_t         ld_data, acc_ext, ext, one_byte;
    logic [CW-1:0] ld_empty;
    logic [CW:0]   n_fill;

    // Map the first n slots onto output symbols; unused symbols stay zero.
    function automatic beat_t place(input beat_t slots, input logic [CW:0] n);
        beat_t b;
        b = '0;
        for (int unsigned k = 0; k < S; k++) begin
            if (k < 32'(n)) begin
                b[(AST_SOURCE_ORDER != 0) ? (S - 1 - k) : k] = slots[k];
            end
        end
        return b;
    endfunction

    function automatic logic [CW-1:0] empty_of(input logic [CW:0] n);
        logic [CW:0] e;
        e = (CW+1)'(S) - n;
        return e[CW-1:0];
    endfunction

    // Next-state: framing, accumulation and output-register loading.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_valid_d = out_valid_q && !ast.ast_source_ready_i;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        err_inc     = 1'b0;
        start_new   = 1'b0;
        ld_en       = 1'b0;
        ld_data     = '0;
        ld_sop      = 1'b0;
        ld_eop      = 1'b0;
        ld_empty    = '0;

        out_free   = !out_valid_q || ast.ast_source_ready_i;
        sink_ready = !main_srst_i && out_free;
        accept     = ast.ast_sink_valid_i && sink_ready;

        acc_ext     = beat_t'({{BYTE_W{1'b0}}, acc_q});
        ext         = acc_ext;
        ext[cnt_q]  = ast.ast_sink_data_i;
        one_byte    = '0;
        one_byte[0] = ast.ast_sink_data_i;
        n_fill      = (CW+1)'(cnt_q) + (CW+1)'(1);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (ast.ast_sink_startofpacket_i) start_new = 1'b1;
                    else err_inc = 1'b1;
                end
            end
            StPkt: begin
                if (accept) begin
                    if (ast.ast_sink_startofpacket_i) begin
                        err_inc = 1'b1;
                        if (cnt_q != '0) begin
                            ld_en    = 1'b1;
                            ld_data  = place(acc_ext, (CW+1)'(cnt_q));
                            ld_sop   = first_q;
                            ld_eop   = 1'b1;
                            ld_empty = empty_of((CW+1)'(cnt_q));
                        end
                        start_new = 1'b1;
                    end else if (ast.ast_sink_endofpacket_i || cnt_q == CW'(S - 1)) begin
                        ld_en    = 1'b1;
                        ld_data  = place(ext, n_fill);
                        ld_sop   = first_q;
                        ld_eop   = ast.ast_sink_endofpacket_i;
                        ld_empty = ast.ast_sink_endofpacket_i ? empty_of(n_fill) : '0;
                        cnt_d    = '0;
                        first_d  = 1'b0;
                        if (ast.ast_sink_endofpacket_i) state_d = StIdle;
                    end else begin
                        acc_d = ext[S-2:0];
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StPend: begin
                if (out_free) begin
                    ld_en    = 1'b1;
                    ld_data  = place(acc_ext, (CW+1)'(1));
                    ld_sop   = 1'b1;
                    ld_eop   = 1'b1;
                    ld_empty = CW'(S - 1);
                    state_d  = StIdle;
                    if (accept) begin
                        if (ast.ast_sink_startofpacket_i) start_new = 1'b1;
                        else err_inc = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_new) begin
            acc_d[0] = ast.ast_sink_data_i;
            first_d  = 1'b1;
            cnt_d    = CW'(1);
            state_d  = StPkt;
            if (ast.ast_sink_endofpacket_i) begin
                cnt_d   = '0;
                first_d = 1'b0;
                if (ld_en) begin
                    state_d = StPend;
                end else begin
                    ld_en    = 1'b1;
                    ld_data  = place(one_byte, (CW+1)'(1));
                    ld_sop   = 1'b1;
                    ld_eop   = 1'b1;
                    ld_empty = CW'(S - 1);
                    state_d  = StIdle;
                end
            end
        end

        if (ld_en) begin
            out_valid_d = 1'b1;
            out_data_d  = ld_data;
            out_sop_d   = ld_sop;
            out_eop_d   = ld_eop;
            out_empty_d = ld_empty;
        end
    end

    // State and output register; reset drops any partial or pending beat.
    always_ff @(posedge main_clk_i) begin
        if (main_srst_i) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ast.ast_sink_ready_o           = sink_ready;
    assign ast.ast_source_data_o          = out_data_q;
    assign ast.ast_source_valid_o         = out_valid_q;
    assign ast.ast_source_startofpacket_o = out_sop_q;
    assign ast.ast_source_endofpacket_o   = out_eop_q;
    assign ast.ast_source_empty_o         = out_empty_q;

`ifdef AST_PACKER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating framing-error counter, cleared only by reset.
    always_ff @(posedge main_clk_i) begin
        if (main_srst_i) begin
            err_cnt_q <= '0;
        end else if (err_inc && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
`endif
endmodule

// File: tb/tb_ast_byte_packer.sv
// Bench for ast_byte_packer: directed scenarios plus random traffic, checked
// against a packet-level reference model (byte lists -> expected beats).
module tb_ast_byte_packer;
    localparam int unsigned S     = 8;
    localparam int unsigned BW    = 8;
    localparam int unsigned EW    = $clog2(S);
    localparam int unsigned ORDER = 1;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    ast_byte_packer_if #(.AST_SOURCE_SYMBOLS(S), .AST_SOURCE_EMPTY_W(EW), .BYTE_W(BW)) bus ();

`ifdef AST_PACKER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    ast_byte_packer #(
        .AST_SOURCE_SYMBOLS(S),
        .AST_SOURCE_ORDER  (ORDER),
        .AST_SOURCE_EMPTY_W(EW),
        .BYTE_W            (BW)
    ) dut (
        .main_clk_i (clk),
        .main_srst_i(srst),
        .ast        (bus)
`ifdef AST_PACKER_ERR_CNT_EN
        ,
        .err_cnt_o  (err_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [S*BW-1:0] data;
        logic            sop;
        logic            eop;
        logic [EW-1:0]   empty;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] cur[$];
    bit         m_in_pkt = 0;
    bit         m_first  = 0;
    int         m_err    = 0;

    function automatic void emit(input bit eop);
        beat_t b;
        int    sym;
        b.data = '0;
        for (int k = 0; k < cur.size(); k++) begin
            sym = (ORDER != 0) ? (S - 1 - k) : k;
            b.data[sym*BW +: BW] = cur[k];
        end
        b.sop   = m_first;
        b.eop   = eop;
        b.empty = eop ? EW'(S - cur.size()) : '0;
        exp_q.push_back(b);
        cur.delete();
        m_first = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] d, input bit sop, input bit eop);
        if (!m_in_pkt) begin
            if (!sop) begin
                m_err++;
                return;
            end
            m_in_pkt = 1;
            m_first  = 1;
        end else if (sop) begin
            m_err++;
            if (cur.size() > 0) emit(1);
            m_first = 1;
        end
        cur.push_back(d);
        if (eop) begin
            emit(1);
            m_in_pkt = 0;
        end else if (cur.size() == S) begin
            emit(0);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        cur.delete();
        m_in_pkt = 0;
        m_first  = 0;
        m_err    = 0;
    endfunction

    // ---------------- source ready driver ----------------
    bit rnd_ready = 0;
    bit force_lo  = 0;
    always @(posedge clk) begin
        #2;
        bus.ast_source_ready_i = force_lo ? 1'b0 :
                                 (rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
    end

    // ---------------- output monitor ----------------
    bit                       hold = 0;
    logic [S*BW+EW+2:0]       held;
    logic [S*BW+EW+2:0]       now_v;
    always @(negedge clk) begin
        now_v = {bus.ast_source_valid_o, bus.ast_source_startofpacket_o,
                 bus.ast_source_endofpacket_o, bus.ast_source_empty_o, bus.ast_source_data_o};
        if (srst) begin
            hold = 0;
        end else begin
            if (hold) check("hold_stable", now_v, held);
            if (bus.ast_source_valid_o && bus.ast_source_ready_i) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", bus.ast_source_data_o, e.data);
                    check("beat_sop", bus.ast_source_startofpacket_o, e.sop);
                    check("beat_eop", bus.ast_source_endofpacket_o, e.eop);
                    check("beat_empty", bus.ast_source_empty_o, e.empty);
                end
                hold = 0;
            end else if (bus.ast_source_valid_o) begin
                hold = 1;
                held = now_v;
            end else begin
                hold = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop);
        int n   = 0;
        bit acc = 0;
        bus.ast_sink_data_i          = d;
        bus.ast_sink_valid_i         = 1'b1;
        bus.ast_sink_startofpacket_i = sop;
        bus.ast_sink_endofpacket_i   = eop;
        while (!acc && n <= 300) begin
            @(negedge clk);
            acc = bus.ast_sink_ready_o;
            @(posedge clk);
            n++;
        end
        if (acc) model_byte(d, sop, eop);
        else check("sink_accept_timeout", acc, 1);
        #1;
        bus.ast_sink_valid_i = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) send_byte(base + 8'(i), i == 0, i == len - 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic check_err(input string tag);
`ifdef AST_PACKER_ERR_CNT_EN
        check(tag, err_cnt, 16'(m_err));
`endif
    endtask

    task automatic pulse_reset();
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.ast_source_valid_o, 0);
        check("rst_sink_ready", bus.ast_sink_ready_o, 0);
        model_reset();
        srst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        srst                         = 1'b1;
        bus.ast_sink_data_i          = '0;
        bus.ast_sink_valid_i         = 1'b0;
        bus.ast_sink_startofpacket_i = 1'b0;
        bus.ast_sink_endofpacket_i   = 1'b0;
        bus.ast_source_ready_i       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.ast_source_valid_o, 0);
        check("rst_sop", bus.ast_source_startofpacket_o, 0);
        check("rst_eop", bus.ast_source_endofpacket_o, 0);
        check("rst_empty", bus.ast_source_empty_o, 0);
        check("rst_data", bus.ast_source_data_o, 0);
        check("rst_sink_ready", bus.ast_sink_ready_o, 0);
        check_err("rst_err_cnt");
        model_reset();
        srst = 1'b0;
        @(posedge clk);
        #1;

        // Full 8-byte packet: beat visible right after the completing edge.
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), i == 1, i == 8);
            if (i == 7) check("s1_no_early_beat", bus.ast_source_valid_o, 0);
        end
        check("s1_latency_valid", bus.ast_source_valid_o, 1);
        check("s1_data", bus.ast_source_data_o, 64'h0102030405060708);
        check("s1_empty", bus.ast_source_empty_o, 0);
        drain(50);

        // 11-byte packet: full beat then 3-byte tail with empty 5.
        send_pkt(8'h10, 11);
        drain(50);

        // Same packet with downstream stalled for 20 cycles after beat 1.
        for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i), i == 0, 0);
        force_lo = 1;
        send_byte(8'h17, 0, 0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #3;
            check("s3_sink_blocked", bus.ast_sink_ready_o, 0);
        end
        force_lo = 0;
        @(posedge clk);
        #1;
        for (int i = 8; i < 11; i++) send_byte(8'h10 + 8'(i), 0, i == 10);
        drain(50);

        // sop inside a packet flushes the partial word.
        send_byte(8'hAA, 1, 0);
        send_byte(8'hBB, 0, 0);
        send_byte(8'hCC, 0, 0);
        send_byte(8'hDD, 1, 1);
        drain(50);
        check_err("s4_err_cnt");

        // Bytes outside a packet are dropped.
        pulse_reset();
        @(posedge clk);
        #1;
        send_byte(8'h55, 0, 0);
        send_byte(8'h66, 0, 0);
        send_byte(8'h77, 1, 1);
        drain(50);
        check_err("s5_err_cnt");

        // Reset mid-packet discards the partial word.
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), i == 0, 0);
        pulse_reset();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 1, i == 8);
        check("s6_valid", bus.ast_source_valid_o, 1);
        check("s6_data", bus.ast_source_data_o, 64'h0102030405060708);
        drain(50);
        check_err("s6_err_cnt");

        // Random traffic with random downstream backpressure.
        rnd_ready = 1;
        for (int i = 0; i < 600; i++) begin
            bit s, e;
            s = m_in_pkt ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 7) != 0);
            e = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_byte(8'($urandom_range(0, 255)), s, e);
        end
        drain(3000);
        check_err("rand_err_cnt");
        rnd_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
